// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  localparam logic [3:0] NO_KEY = 4'b1111;

  // Nibble at {row, col} holds the hex legend of that key: row0 = 1 2 3 A ... row3 = 0 F E D.
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction

  function automatic logic one_low(input logic [3:0] pat);
    return $countones(~pat) == 1;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] pat);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!pat[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// Scan-rate divider: one-cycle tick every SCAN_DIV clocks, first tick in cycle SCAN_DIV after reset.
module keypad_tick #(
  parameter int SCAN_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [W-1:0] div_q;

  assign tick_o = (div_q == W'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick_o) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low row at a time, debounced press/release,
// one-cycle key_valid strobe per accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_SCANS);

  logic       tick;
  logic [3:0] col_meta_q;
  logic [3:0] col_sync_q;
  state_e     state_q;
  logic [1:0] r_q;
  logic [3:0] row_q;
  logic [3:0] pat_q;
  logic [1:0] cidx_q;
  logic [3:0] cnt_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_held_q;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // col is asynchronous to clk; only the second stage is ever decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= NO_KEY;
      col_sync_q <= NO_KEY;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      r_q         <= 2'd0;
      row_q       <= 4'b1110;
      pat_q       <= NO_KEY;
      cidx_q      <= 2'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (one_low(col_sync_q)) begin
              pat_q  <= col_sync_q;
              cidx_q <= low_index(col_sync_q);
              if (DEB_CNT == 4'd1) begin
                key_code_q  <= key_map(r_q, low_index(col_sync_q));
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= 4'd0;
                state_q     <= PRESSED;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= DEBOUNCE;
              end
            end else begin
              r_q   <= r_q + 2'd1;
              row_q <= {row_q[2:0], row_q[3]};
            end
          end
          DEBOUNCE: begin
            if (col_sync_q == pat_q) begin
              if (cnt_q + 4'd1 == DEB_CNT) begin
                key_code_q  <= key_map(r_q, cidx_q);
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= 4'd0;
                state_q     <= PRESSED;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              r_q     <= r_q + 2'd1;
              row_q   <= {row_q[2:0], row_q[3]};
              state_q <= SCAN;
            end
          end
          PRESSED: begin
            // Any low column keeps the key held, including a second key on this row.
            if (col_sync_q == NO_KEY) begin
              if (DEB_CNT == 4'd1) begin
                key_held_q <= 1'b0;
                cnt_q      <= 4'd0;
                r_q        <= r_q + 2'd1;
                row_q      <= {row_q[2:0], row_q[3]};
                state_q    <= SCAN;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (col_sync_q == NO_KEY) begin
              if (cnt_q + 4'd1 == DEB_CNT) begin
                key_held_q <= 1'b0;
                cnt_q      <= 4'd0;
                r_q        <= r_q + 2'd1;
                row_q      <= {row_q[2:0], row_q[3]};
                state_q    <= SCAN;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= PRESSED;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 and a behavioural keypad matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed = 16'h0000;  // bit {r,c} set = key at row r, column c pressed
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pulses = 0;
  int          cyc = 0;
  int          base;
  int          changes;
  logic [3:0]  prev_row;
  bit          seen;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid) n_pulses <= n_pulses + 1;
    cyc <= rst ? 0 : cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      if (key_valid) hit = 1'b1;
    end
  endtask

  task automatic wait_release(input int max_cyc, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      if (!key_held) hit = 1'b1;
    end
  endtask

  initial begin
    // 1. Reset, no key: one row step per tick on cycles 4, 8, 12, 16.
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    check("rst_row", row, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    base = n_pulses;
    prev_row = 4'b1110;
    for (int k = 1; k <= 4; k++) begin
      cycles(3);
      check("scan_hold_row", row, prev_row);
      cycles(1);
      prev_row = {prev_row[2:0], prev_row[3]};
      check("scan_step_row", row, prev_row);
      check("scan_step_cyc", cyc, 4 * k);
    end
    check("scan_no_valid", n_pulses - base, 0);

    // 2. Press "5": row1 arrives at cycle 20, ticks 24/28/32 debounce, strobe in cycle 33.
    pressed = 16'h1 << 5;
    wait_valid(60, seen);
    check("k5_valid_seen", seen, 1'b1);
    check("k5_latency", cyc, 32);
    check("k5_code", key_code, 4'h5);
    check("k5_held", key_held, 1'b1);
    check("k5_row", row, 4'b1101);
    cycles(1);
    check("k5_pulse_width", key_valid, 1'b0);
    cycles(40);
    check("k5_row_frozen", row, 4'b1101);
    check("k5_one_pulse", n_pulses - base, 1);
    pressed = 16'h0;
    wait_release(40, seen);
    check("k5_released", seen, 1'b1);
    check("k5_resume_row", row, 4'b1011);

    // 3. Bounce on key 9: low for two ticks only, then a stable press.
    base = n_pulses;
    pressed = 16'h1 << 10;
    cycles(9);
    pressed = 16'h0;
    cycles(3);
    check("bounce_row_adv", row, 4'b0111);
    check("bounce_code", key_code, 4'h5);
    check("bounce_no_valid", n_pulses - base, 0);
    pressed = 16'h1 << 10;
    wait_valid(80, seen);
    check("k9_valid_seen", seen, 1'b1);
    check("k9_code", key_code, 4'h9);
    pressed = 16'h0;
    wait_release(40, seen);
    check("k9_released", seen, 1'b1);

    // 4. Multi-key on row3 (cols 0 and 3): rejected, scanning never stalls.
    base = n_pulses;
    pressed = (16'h1 << 12) | (16'h1 << 15);
    changes = 0;
    prev_row = row;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (row != prev_row) changes++;
      prev_row = row;
    end
    check("multi_row_steps", changes, 16);
    check("multi_no_valid", n_pulses - base, 0);
    check("multi_held", key_held, 1'b0);

    // 5. Key D with release bounce: 2 high ticks, low, then 3 high ticks.
    pressed = 16'h1 << 15;
    wait_valid(80, seen);
    check("kd_valid_seen", seen, 1'b1);
    check("kd_code", key_code, 4'hD);
    pressed = 16'h0;
    cycles(9);
    pressed = 16'h1 << 15;
    cycles(4);
    check("kd_bounce_held", key_held, 1'b1);
    pressed = 16'h0;
    cycles(10);
    check("kd_still_held", key_held, 1'b1);
    cycles(1);
    check("kd_released", key_held, 1'b0);
    check("kd_next_row", row, 4'b1110);
    check("kd_one_pulse", n_pulses - base, 1);

    // 6. Reset while debouncing key A, key kept down through and after reset.
    pressed = 16'h1 << 3;
    cycles(5);
    check("ka_row_held", row, 4'b1110);
    base = n_pulses;
    rst = 1'b1;
    cycles(2);
    check("ka_rst_row", row, 4'b1110);
    check("ka_rst_code", key_code, 4'h0);
    check("ka_rst_held", key_held, 1'b0);
    check("ka_rst_valid", key_valid, 1'b0);
    rst = 1'b0;
    wait_valid(40, seen);
    check("ka_valid_seen", seen, 1'b1);
    check("ka_latency", cyc, 12);
    check("ka_code", key_code, 4'hA);
    cycles(1);
    check("ka_pulse_width", key_valid, 1'b0);
    cycles(30);
    check("ka_one_pulse", n_pulses - base, 1);
    check("ka_held", key_held, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and reports each debounced keypress as a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the multiplexed 7-segment display driver. It drives one active-low row at a time, the way the display driver drives one anode at a time, and reads the active-low columns. Its outputs feed the parking controller's entry logic and the digit registers that the display shows.

Parameters:
SCAN_DIV, 2500, clk cycles per scan tick; tick when divider == SCAN_DIV-1; legal range >= 2.
DEBOUNCE_SCANS, 4, consecutive matching ticks needed to accept a press or a release; legal range 1..15.

Ports:
clk  input  1  system clock; the block's only clock.
rst  input  1  synchronous, active-high reset.
col  input  4  keypad columns, active low, externally pulled up, asynchronous to clk.
row  output 4  keypad rows, active low, exactly one bit low at all times.
key_code  output 4  hex code of the last accepted key; held until the next accepted key.
key_valid  output 1  one-clk pulse when a new key is accepted.
key_held  output 1  high while the accepted key is still considered pressed.

Behaviour:
- Clocking and reset: one clock (clk). Synchronous, active-high reset (rst), sampled on posedge clk.
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, divider=0, debounce count=0, synchroniser flops=4'b1111.
- Column synchroniser: col passes through a 2-FF synchroniser; all decisions use the synchronised value (colS).
- Tick: the divider counts 0..SCAN_DIV-1 and wraps. tick is high for one clk when divider==SCAN_DIV-1. The first tick after reset is in cycle SCAN_DIV.
- Sampling: colS is evaluated only on tick cycles. When the row advances, it advances in that same cycle, so each row settles for a full tick period before it is sampled.
- Row index r: 0..3, wraps 3->0. row = ~(4'b0001 << r).
- Key map (row,col -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - col index 0 is colS[0].
- Valid pattern: exactly one colS bit is low. All-high means no key. Two or more low bits are treated as no key (multi-key rejection).
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
  - SCAN, on tick:
    - valid pattern: latch r and column, count=1, go to DEBOUNCE; row is held.
    - otherwise: advance r.
    - If DEBOUNCE_SCANS==1, a valid pattern goes directly to the PRESSED entry actions.
  - DEBOUNCE, on tick:
    - colS equals the latched pattern: count++.
    - When count reaches DEBOUNCE_SCANS: key_code <= map(latched), key_valid pulses in the next clk cycle for exactly one cycle, key_held <= 1, go to PRESSED.
    - Any mismatch (including all-high or a different column): count=0, advance r, go to SCAN. No outputs change.
  - PRESSED, on tick:
    - colS all-high: count=1, go to RELEASE.
    - Otherwise stay in PRESSED. A different key on the same row is ignored.
  - RELEASE, on tick:
    - colS all-high: count++. When count reaches DEBOUNCE_SCANS: key_held <= 0, count=0, advance r, go to SCAN.
    - Any key low: return to PRESSED, key_held stays 1. There is no new key_valid (this is bounce on release).
- Hold behaviour: a held key produces exactly one key_valid, with no auto-repeat. key_code is never cleared except by rst.
- Reset mid-operation: all state returns to reset values and no pulse is emitted. A key still held after rst is re-detected from SCAN and produces a fresh key_valid after the full debounce.
- Latency: from a stable press whose row is already driven, key_valid is high one clk after the DEBOUNCE_SCANS-th matching tick.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - 16-entry key map constant indexed by {row, col}
  - NO_KEY = 4'b1111 constant
- Natural sub-module keypad_tick: divider and tick generation with synchronous reset, parameterised by SCAN_DIV.
- Synchroniser, FSM and outputs stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
1. Reset, no key: after rst, row cycles 1110->1101->1011->0111->1110, advancing on cycles 4, 8, 12, 16 (one step per tick). key_valid stays 0.
2. Press "5" (row1, col1): hold colS[1]=0 whenever row==1101. Exactly one key_valid pulse, key_code=4'h5, key_held=1, row frozen at 1101. Release for 3 ticks: key_held=0 and scanning resumes.
3. Bounce: on row r2, col2 is low for 2 ticks and then high. No key_valid and key_code unchanged. Then a stable press accepts key_code=4'h9.
4. Multi-key: col0 and col3 are low together on row3. No key_valid is ever produced and scanning continues.
5. Release bounce: in PRESSED with key "D", apply 2 high ticks, then low, then 3 high ticks. key_held stays 1 until the final release and there is only one key_valid in total.
6. Mid-press reset: assert rst during DEBOUNCE on key "A". Outputs return to reset values. Keep the key held: a single key_valid with key_code=4'hA appears after re-scan and debounce.
